acc_drain: RTL

Read-out side of the MAC accumulator chain. Captures one completed accumulator word (`MAC_ACC_WIDTH` bits plus the chain's final carry) through a valid/ready handshake. Streams the word out as `MAC_ACC_WIDTH/MAC_MIN_WIDTH` chunks of `MAC_MIN_WIDTH` bits on a second valid/ready port, at up to one chunk per cycle. It sits between the accumulator array and the narrow result bus, and is the counterpart of the wide-sum accumulation path.

---
 rtl/acc_drain_if.sv | 32 +++
 rtl/acc_drain.sv | 116 +++++++++++
 2 files changed

// File: rtl/acc_drain_if.sv
`default_nettype none
// ============================================================================
// Module   : acc_drain_if
// Brief    : Word-capture and chunk-stream handshake bundle for acc_drain.
// Revision : 1.0 - initial release
// ============================================================================
interface acc_drain_if #(
    parameter int MAC_MIN_WIDTH = 8,
    parameter int MAC_ACC_WIDTH = 4 * MAC_MIN_WIDTH
);
    logic                     in_valid;
    logic                     in_ready;
    logic [MAC_ACC_WIDTH-1:0] in_data;
    logic                     in_carry;
    logic                     out_valid;
    logic                     out_ready;
    logic [MAC_MIN_WIDTH-1:0] out_data;
    logic                     out_last;
    logic                     out_ovf;
    logic                     busy;

    modport master (
        output in_valid, in_data, in_carry, out_ready,
        input  in_ready, out_valid, out_data, out_last, out_ovf, busy
    );

    modport slave (
        input  in_valid, in_data, in_carry, out_ready,
        output in_ready, out_valid, out_data, out_last, out_ovf, busy
    );
endinterface
`default_nettype wire

// File: rtl/acc_drain.sv
`default_nettype none
// ============================================================================
// Module   : acc_drain
// Brief    : Captures one accumulator word plus final carry and streams it
//            out as MAC_MIN_WIDTH-bit chunks, one per cycle at best.
// Revision : 1.0 - initial release
// ============================================================================
module acc_drain #(
    parameter int MAC_MIN_WIDTH = 8,
    parameter int MAC_ACC_WIDTH = 4 * MAC_MIN_WIDTH,
    parameter bit MSB_FIRST     = 1'b0
) (
    input wire         clk,
    input wire         rst_n,
    acc_drain_if.slave bus
);
    localparam int c_N     = MAC_ACC_WIDTH / MAC_MIN_WIDTH;
    localparam int c_CNT_W = $clog2(c_N);
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(c_N - 1);
    localparam logic [c_CNT_W-1:0] c_CNT_ONE  = c_CNT_W'(1);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_SEND = 1'b1
    } state_t;

    state_t                   r_state, w_state_nx;
    logic [c_CNT_W-1:0]       r_cnt, w_cnt_nx;
    logic [MAC_ACC_WIDTH-1:0] r_shreg, w_shreg_nx, w_shreg_shift;
    logic                     r_carry, w_carry_nx;

    logic                     w_send;
    logic                     w_last;
    logic                     w_in_ready;
    logic                     w_in_fire;
    logic                     w_out_fire;
    logic [MAC_MIN_WIDTH-1:0] w_chunk;

    assign w_send     = (r_state == ST_SEND);
    assign w_last     = w_send && (r_cnt == c_CNT_LAST);
    // Accepting on the last-chunk fire lets back-to-back words stream bubble-free.
    assign w_in_ready = !w_send || (w_last && bus.out_ready);
    assign w_in_fire  = bus.in_valid && w_in_ready;
    assign w_out_fire = w_send && bus.out_ready;

    generate
        if (MSB_FIRST) begin : g_msb_first
            assign w_chunk       = r_shreg[MAC_ACC_WIDTH-1 -: MAC_MIN_WIDTH];
            assign w_shreg_shift = r_shreg << MAC_MIN_WIDTH;
        end else begin : g_lsb_first
            assign w_chunk       = r_shreg[MAC_MIN_WIDTH-1:0];
            assign w_shreg_shift = r_shreg >> MAC_MIN_WIDTH;
        end
    endgenerate

    always_comb begin
        w_state_nx = r_state;
        w_cnt_nx   = r_cnt;
        w_shreg_nx = r_shreg;
        w_carry_nx = r_carry;
        unique case (r_state)
            ST_IDLE: begin
                if (w_in_fire) begin
                    w_state_nx = ST_SEND;
                    w_shreg_nx = bus.in_data;
                    w_carry_nx = bus.in_carry;
                    w_cnt_nx   = '0;
                end
            end
            ST_SEND: begin
                if (w_out_fire) begin
                    if (!w_last) begin
                        w_shreg_nx = w_shreg_shift;
                        w_cnt_nx   = r_cnt + c_CNT_ONE;
                    end else if (w_in_fire) begin
                        w_state_nx = ST_SEND;
                        w_shreg_nx = bus.in_data;
                        w_carry_nx = bus.in_carry;
                        w_cnt_nx   = '0;
                    end else begin
                        // Clearing on exit keeps out_data at zero while idle.
                        w_state_nx = ST_IDLE;
                        w_shreg_nx = '0;
                        w_carry_nx = 1'b0;
                        w_cnt_nx   = '0;
                    end
                end
            end
            default: begin
                w_state_nx = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_shreg <= '0;
            r_carry <= 1'b0;
        end else begin
            r_state <= w_state_nx;
            r_cnt   <= w_cnt_nx;
            r_shreg <= w_shreg_nx;
            r_carry <= w_carry_nx;
        end
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = w_send;
    assign bus.out_data  = w_chunk;
    assign bus.out_last  = w_last;
    assign bus.out_ovf   = w_last && r_carry;
    assign bus.busy      = w_send;
endmodule
`default_nettype wire
